// File: rtl/twd_mul_trivial_if.sv
// rtl/twd_mul_trivial_if.sv - beat bus between a butterfly stage and the trivial-twiddle stage
// The stage is the slave; the upstream producer and downstream sink share the master view.
interface twd_mul_trivial_if #(
  parameter int WIDTH = 12,
  parameter int LANES = 16
);
  logic                         i_valid;
  logic                         i_sof;
  logic                         i_inverse;
  logic [LANES-1:0][WIDTH-1:0]  i_sum_re;
  logic [LANES-1:0][WIDTH-1:0]  i_sum_im;
  logic [LANES-1:0][WIDTH-1:0]  i_diff_re;
  logic [LANES-1:0][WIDTH-1:0]  i_diff_im;
  logic                         o_valid;
  logic [1:0]                   o_rot_idx;
  logic [LANES-1:0][WIDTH-1:0]  o_sum_re;
  logic [LANES-1:0][WIDTH-1:0]  o_sum_im;
  logic [LANES-1:0][WIDTH-1:0]  o_diff_re;
  logic [LANES-1:0][WIDTH-1:0]  o_diff_im;

  modport master (
    output i_valid, i_sof, i_inverse, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
    input  o_valid, o_rot_idx, o_sum_re, o_sum_im, o_diff_re, o_diff_im
  );

  modport slave (
    input  i_valid, i_sof, i_inverse, i_sum_re, i_sum_im, i_diff_re, i_diff_im,
    output o_valid, o_rot_idx, o_sum_re, o_sum_im, o_diff_re, o_diff_im
  );
endinterface

// File: rtl/twd_mul_trivial.sv
// rtl/twd_mul_trivial.sv - multiplier-free twiddle stage: diff path rotated by 1/-j/-1/+j, sum path registered
// One-cycle registered latency, no backpressure; rotation chosen by a beat counter restarted on sof.
module twd_mul_trivial #(
  parameter int WIDTH     = 12,
  parameter int LANES     = 16,
  parameter int CNT_W     = 4,
  parameter int ROT_SHIFT = 0,
  parameter int ROT_MODE  = 0,
  parameter int SATURATE  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  twd_mul_trivial_if.slave bus
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            beat_cnt;
  logic [1:0]                  k_raw;
  logic [1:0]                  k;
  logic [LANES-1:0][WIDTH-1:0] rot_re;
  logic [LANES-1:0][WIDTH-1:0] rot_im;

  // A sof beat behaves as beat 0 regardless of where the counter was.
  assign beat_cnt = bus.i_sof ? '0 : cnt;

  generate
    if (ROT_MODE == 0) begin : g_two_point
      assign k_raw = {1'b0, beat_cnt[ROT_SHIFT]};
    end else begin : g_four_point
      assign k_raw = beat_cnt[ROT_SHIFT+1:ROT_SHIFT];
    end
  endgenerate

  // Inverse transform conjugates the twiddle: -j and +j swap, 1 and -1 are unchanged.
  assign k = (bus.i_inverse && k_raw[0]) ? (k_raw ^ 2'b10) : k_raw;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    if (SATURATE != 0 && x == MOST_NEG) begin
      return MOST_POS;
    end
    return -x;
  endfunction

  always_comb begin
    rot_re = '0;
    rot_im = '0;
    for (int l = 0; l < LANES; l++) begin
      case (k)
        2'd0: begin
          rot_re[l] = bus.i_diff_re[l];
          rot_im[l] = bus.i_diff_im[l];
        end
        2'd1: begin
          rot_re[l] = bus.i_diff_im[l];
          rot_im[l] = neg(bus.i_diff_re[l]);
        end
        2'd2: begin
          rot_re[l] = neg(bus.i_diff_re[l]);
          rot_im[l] = neg(bus.i_diff_im[l]);
        end
        default: begin
          rot_re[l] = neg(bus.i_diff_im[l]);
          rot_im[l] = bus.i_diff_re[l];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt           <= '0;
      bus.o_valid   <= 1'b0;
      bus.o_rot_idx <= 2'd0;
      bus.o_sum_re  <= '0;
      bus.o_sum_im  <= '0;
      bus.o_diff_re <= '0;
      bus.o_diff_im <= '0;
    end else begin
      bus.o_valid <= bus.i_valid;
      if (bus.i_valid) begin
        cnt           <= beat_cnt + CNT_W'(1);
        bus.o_rot_idx <= k;
        bus.o_sum_re  <= bus.i_sum_re;
        bus.o_sum_im  <= bus.i_sum_im;
        bus.o_diff_re <= rot_re;
        bus.o_diff_im <= rot_im;
      end
    end
  end

endmodule

// File: tb/tb_twd_mul_trivial.sv
// tb/tb_twd_mul_trivial.sv - directed bench for twd_mul_trivial across 2/4-point and saturating/wrapping builds
module tb_twd_mul_trivial;
  localparam int W = 12;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rstn;
  logic v, sof, inv;
  logic [L-1:0][W-1:0] sre, sim, dre, dim;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: 4-point saturating, b: 2-point saturating, c: 4-point wrapping
  twd_mul_trivial_if #(.WIDTH(W), .LANES(L)) bus_a ();
  twd_mul_trivial_if #(.WIDTH(W), .LANES(L)) bus_b ();
  twd_mul_trivial_if #(.WIDTH(W), .LANES(L)) bus_c ();

  assign bus_a.i_valid = v;   assign bus_a.i_sof = sof;   assign bus_a.i_inverse = inv;
  assign bus_a.i_sum_re = sre; assign bus_a.i_sum_im = sim; assign bus_a.i_diff_re = dre; assign bus_a.i_diff_im = dim;
  assign bus_b.i_valid = v;   assign bus_b.i_sof = sof;   assign bus_b.i_inverse = inv;
  assign bus_b.i_sum_re = sre; assign bus_b.i_sum_im = sim; assign bus_b.i_diff_re = dre; assign bus_b.i_diff_im = dim;
  assign bus_c.i_valid = v;   assign bus_c.i_sof = sof;   assign bus_c.i_inverse = inv;
  assign bus_c.i_sum_re = sre; assign bus_c.i_sum_im = sim; assign bus_c.i_diff_re = dre; assign bus_c.i_diff_im = dim;

  twd_mul_trivial #(.WIDTH(W), .LANES(L), .CNT_W(4), .ROT_SHIFT(0), .ROT_MODE(1), .SATURATE(1))
    u_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  twd_mul_trivial #(.WIDTH(W), .LANES(L), .CNT_W(4), .ROT_SHIFT(0), .ROT_MODE(0), .SATURATE(1))
    u_b (.clk(clk), .rstn(rstn), .bus(bus_b));
  twd_mul_trivial #(.WIDTH(W), .LANES(L), .CNT_W(4), .ROT_SHIFT(0), .ROT_MODE(1), .SATURATE(0))
    u_c (.clk(clk), .rstn(rstn), .bus(bus_c));

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_diff(input int re, input int im);
    for (int l = 0; l < L; l++) begin
      dre[l] = re[W-1:0];
      dim[l] = im[W-1:0];
    end
  endtask

  task automatic set_sum(input int re, input int im);
    for (int l = 0; l < L; l++) begin
      sre[l] = re[W-1:0];
      sim[l] = im[W-1:0];
    end
  endtask

  // Called at posedge+1; inputs change away from the edge, outputs sampled 1 unit after the next edge.
  task automatic step(input logic vv, input logic ss, input logic ii);
    v = vv;
    sof = ss;
    inv = ii;
    @(posedge clk);
    #1;
  endtask

  // Checks valid, rotation index and diff lanes 0 and L-1 of one instance.
  task automatic chk_beat(input string tag, input int which, input int re, input int im, input int k);
    logic signed [31:0] r0, i0, rn, in_, kk, vv;
    case (which)
      0: begin
        r0 = $signed(bus_a.o_diff_re[0]); i0 = $signed(bus_a.o_diff_im[0]);
        rn = $signed(bus_a.o_diff_re[L-1]); in_ = $signed(bus_a.o_diff_im[L-1]);
        kk = 32'(bus_a.o_rot_idx); vv = 32'(bus_a.o_valid);
      end
      1: begin
        r0 = $signed(bus_b.o_diff_re[0]); i0 = $signed(bus_b.o_diff_im[0]);
        rn = $signed(bus_b.o_diff_re[L-1]); in_ = $signed(bus_b.o_diff_im[L-1]);
        kk = 32'(bus_b.o_rot_idx); vv = 32'(bus_b.o_valid);
      end
      default: begin
        r0 = $signed(bus_c.o_diff_re[0]); i0 = $signed(bus_c.o_diff_im[0]);
        rn = $signed(bus_c.o_diff_re[L-1]); in_ = $signed(bus_c.o_diff_im[L-1]);
        kk = 32'(bus_c.o_rot_idx); vv = 32'(bus_c.o_valid);
      end
    endcase
    check({tag, ".valid"}, vv, 1);
    check({tag, ".rot"}, kk, k);
    check({tag, ".re0"}, r0, re);
    check({tag, ".im0"}, i0, im);
    check({tag, ".reN"}, rn, re);
    check({tag, ".imN"}, in_, im);
  endtask

  int exp_re4[4] = '{3, 7, -3, -7};
  int exp_im4[4] = '{7, -3, -7, 3};
  int inv_re4[4] = '{3, -7, -3, 7};
  int inv_im4[4] = '{7, 3, -7, -3};
  int m0_re[2]   = '{100, -50};
  int m0_im[2]   = '{-50, -100};

  initial begin
    rstn = 1'b0;
    v = 1'b0; sof = 1'b0; inv = 1'b0;
    set_sum(0, 0);
    set_diff(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", 32'(bus_a.o_valid), 0);
    check("rst.rot", 32'(bus_a.o_rot_idx), 0);
    check("rst.diff_or", 32'(|{bus_a.o_diff_re, bus_a.o_diff_im}), 0);
    check("rst.sum_or", 32'(|{bus_a.o_sum_re, bus_a.o_sum_im}), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 2-point pattern, sum path passes through untouched
    set_diff(100, -50);
    set_sum(5, -6);
    for (int n = 0; n < 4; n++) begin
      step(1'b1, n == 0, 1'b0);
      chk_beat($sformatf("m0.b%0d", n), 1, m0_re[n % 2], m0_im[n % 2], n % 2);
      check($sformatf("m0.sum_re%0d", n), $signed(bus_b.o_sum_re[L-1]), 5);
      check($sformatf("m0.sum_im%0d", n), $signed(bus_b.o_sum_im[0]), -6);
    end

    // 4-point pattern, forward then inverse
    set_diff(3, 7);
    for (int n = 0; n < 4; n++) begin
      step(1'b1, n == 0, 1'b0);
      chk_beat($sformatf("m1f.b%0d", n), 0, exp_re4[n], exp_im4[n], n);
    end
    for (int n = 0; n < 4; n++) begin
      step(1'b1, n == 0, 1'b1);
      chk_beat($sformatf("m1i.b%0d", n), 0, inv_re4[n], inv_im4[n], (4 - n) % 4);
    end

    // negating the most negative value: saturate vs wrap at k=2
    set_diff(0, 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    set_diff(-2048, -2048);
    step(1'b1, 1'b0, 1'b0);
    chk_beat("sat1", 0, 2047, 2047, 2);
    chk_beat("sat0", 2, -2048, -2048, 2);
    step(1'b1, 1'b0, 1'b0);
    chk_beat("sat1.k3", 0, 2047, -2048, 3);

    // counter wrap after 16 beats, idle gaps hold data, late sof restarts at k=0
    set_diff(3, 7);
    for (int n = 0; n < 17; n++) begin
      step(1'b1, n == 0, 1'b0);
      chk_beat($sformatf("wrap.a%0d", n), 0, exp_re4[n % 4], exp_im4[n % 4], n % 4);
      check($sformatf("wrap.b%0d.rot", n), 32'(bus_b.o_rot_idx), n % 2);
      if (n % 3 == 1) begin
        step(1'b0, 1'b1, 1'b0);
        check($sformatf("gap%0d.valid", n), 32'(bus_a.o_valid), 0);
        check($sformatf("gap%0d.rot", n), 32'(bus_a.o_rot_idx), n % 4);
        check($sformatf("gap%0d.re", n), $signed(bus_a.o_diff_re[3]), exp_re4[n % 4]);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    chk_beat("sof18", 0, 3, 7, 0);

    // distinct ramp per lane, k=0 then k=1
    for (int l = 0; l < L; l++) begin
      dre[l] = 12'(l * 37 + 1);
      dim[l] = 12'(-(l * 53) - 5);
      sre[l] = 12'(l * 11);
      sim[l] = 12'(-l);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < L; l++) begin
      check($sformatf("ramp.re%0d", l), $signed(bus_a.o_diff_re[l]), -(l * 53) - 5);
      check($sformatf("ramp.im%0d", l), $signed(bus_a.o_diff_im[l]), -(l * 37 + 1));
      check($sformatf("ramp.sre%0d", l), $signed(bus_a.o_sum_re[l]), l * 11);
      check($sformatf("ramp.sim%0d", l), $signed(bus_a.o_sum_im[l]), -l);
    end

    // async reset mid-stream, counter restarts at 0 without sof
    set_diff(3, 7);
    step(1'b1, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst.valid", 32'(bus_a.o_valid), 0);
    check("mrst.rot", 32'(bus_a.o_rot_idx), 0);
    check("mrst.diff_or", 32'(|{bus_a.o_diff_re, bus_a.o_diff_im}), 0);
    check("mrst.sum_or", 32'(|{bus_a.o_sum_re, bus_a.o_sum_im}), 0);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk_beat("post_rst", 0, 3, 7, 0);
    step(1'b1, 1'b0, 1'b0);
    chk_beat("post_rst2", 0, 7, -3, 1);
    step(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
